// File: rtl/ce_generator_if.sv
// Bundle of control inputs and strobe outputs for the clock-enable generator.
interface ce_generator_if;
  logic [1:0] speed;
  logic       pause;
  logic       ce_f1;
  logic       ce_f2;
  logic       ce_pix;
  logic       ce_aux;
  logic [1:0] speed_cur;

  // Consumer side: requests speed/pause, receives strobes.
  modport master (
    output speed, pause,
    input  ce_f1, ce_f2, ce_pix, ce_aux, speed_cur
  );

  // Generator side.
  modport slave (
    input  speed, pause,
    output ce_f1, ce_f2, ce_pix, ce_aux, speed_cur
  );
endinterface

// File: rtl/ce_generator.sv
// Clock-enable strobe generator: two-phase CPU strobes with speed multiplier
// and pair-preserving pause, plus free-running pixel and auxiliary strobes.
module ce_generator #(
  parameter int unsigned CPU_DIV   = 24,
  parameter int unsigned F2_OFFSET = 2,
  parameter int unsigned MAX_SPEED = 3,
  parameter int unsigned PIX_DIV   = 3,
  parameter int unsigned AUX_DIV   = 3571
) (
  input  logic clk,
  input  logic reset,
  ce_generator_if.slave bus
);

  localparam int unsigned CPU_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  localparam int unsigned PIX_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned AUX_W = (AUX_DIV > 1) ? $clog2(AUX_DIV) : 1;
  localparam logic [1:0]  SPEED_MAX = 2'(MAX_SPEED);

  // Reject parameter sets that cannot produce evenly spaced, unsplit pairs.
  if (MAX_SPEED > 3) begin : g_bad_max_speed
    $error("ce_generator: MAX_SPEED must fit the 2-bit speed code");
  end
  if ((CPU_DIV % (1 << MAX_SPEED)) != 0) begin : g_bad_cpu_div
    $error("ce_generator: CPU_DIV must be divisible by 2**MAX_SPEED");
  end
  if (F2_OFFSET < 1 || F2_OFFSET >= (CPU_DIV >> MAX_SPEED)) begin : g_bad_f2
    $error("ce_generator: F2_OFFSET must lie in [1, CPU_DIV>>MAX_SPEED)");
  end
  if (PIX_DIV < 1 || AUX_DIV < 1) begin : g_bad_div
    $error("ce_generator: PIX_DIV and AUX_DIV must be at least 1");
  end

  logic [CPU_W-1:0] cpu_div;
  logic [CPU_W-1:0] ph;
  logic [CPU_W-1:0] sub_last;
  logic [PIX_W-1:0] pix_div;
  logic [AUX_W-1:0] aux_div;
  logic [1:0]       speed_q;
  logic [1:0]       speed_clamped;
  logic             period_end;
  logic             sub_end;
  logic             f1_slot;
  logic             f2_slot;
  logic             paused;
  logic             f1_q, f2_q, pix_q, aux_q;

  // Slot decode from pre-increment counter values.
  always_comb begin
    sub_last      = CPU_W'((CPU_DIV >> speed_q) - 1);
    period_end    = (cpu_div == CPU_W'(CPU_DIV - 1));
    sub_end       = (ph == sub_last);
    f1_slot       = (ph == '0);
    f2_slot       = (ph == CPU_W'(F2_OFFSET));
    speed_clamped = (bus.speed > SPEED_MAX) ? SPEED_MAX : bus.speed;
  end

  // Period, phase and free-running divider counters; speed latched per period.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_div <= '0;
      ph      <= '0;
      pix_div <= '0;
      aux_div <= '0;
      speed_q <= '0;
    end else begin
      cpu_div <= period_end ? '0 : cpu_div + 1'b1;
      // Phase wraps with the period too, so a speed change lands on ph==0.
      ph      <= (period_end || sub_end) ? '0 : ph + 1'b1;
      pix_div <= (pix_div == PIX_W'(PIX_DIV - 1)) ? '0 : pix_div + 1'b1;
      aux_div <= (aux_div == AUX_W'(AUX_DIV - 1)) ? '0 : aux_div + 1'b1;
      if (period_end) begin
        speed_q <= speed_clamped;
      end
    end
  end

  // Strobe registers; pause is only sampled at the f1 slot so pairs stay whole.
  always_ff @(posedge clk) begin
    if (reset) begin
      f1_q   <= 1'b0;
      f2_q   <= 1'b0;
      pix_q  <= 1'b0;
      aux_q  <= 1'b0;
      paused <= 1'b0;
    end else begin
      f1_q  <= f1_slot && !bus.pause;
      f2_q  <= f2_slot && !paused;
      pix_q <= (pix_div == '0);
      aux_q <= (aux_div == '0);
      if (f1_slot) begin
        paused <= bus.pause;
      end
    end
  end

  assign bus.ce_f1     = f1_q;
  assign bus.ce_f2     = f2_q;
  assign bus.ce_pix    = pix_q;
  assign bus.ce_aux    = aux_q;
  assign bus.speed_cur = speed_q;

endmodule

// File: tb/tb_ce_generator.sv
// Directed bench for ce_generator: default build, MAX_SPEED=2 build and a
// small-divider build with a random speed/pause soak.
module tb_ce_generator;

  logic clk;
  logic r0, r1, r2;
  int   cyc;
  int   n_checks;
  int   n_fail;

  ce_generator_if b0 ();
  ce_generator_if b1 ();
  ce_generator_if b2 ();

  ce_generator u_dut0 (.clk(clk), .reset(r0), .bus(b0));
  ce_generator #(.MAX_SPEED(2)) u_dut1 (.clk(clk), .reset(r1), .bus(b1));
  ce_generator #(.CPU_DIV(16), .F2_OFFSET(1), .PIX_DIV(1), .AUX_DIV(5))
    u_dut2 (.clk(clk), .reset(r2), .bus(b2));

  // Clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [5:0] outs(input int d);
    case (d)
      0:       return {b0.speed_cur, b0.ce_f1, b0.ce_f2, b0.ce_pix, b0.ce_aux};
      1:       return {b1.speed_cur, b1.ce_f1, b1.ce_f2, b1.ce_pix, b1.ce_aux};
      default: return {b2.speed_cur, b2.ce_f1, b2.ce_f2, b2.ce_pix, b2.ce_aux};
    endcase
  endfunction

  task automatic set_reset(input int d, input logic v);
    case (d)
      0:       r0 = v;
      1:       r1 = v;
      default: r2 = v;
    endcase
  endtask

  // Hold reset two edges, check all outputs are zero, release; next sample is cycle 1.
  task automatic hold_reset(input int d);
    set_reset(d, 1'b1);
    tick();
    tick();
    check("rst_outs", 32'(outs(d)), 32'd0);
    set_reset(d, 1'b0);
    cyc = 0;
  endtask

  initial begin
    int n;
    int g;
    logic prev_f1;

    clk = 1'b0;
    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
    cyc = 0; n_checks = 0; n_fail = 0;
    b0.speed = 2'd0; b0.pause = 1'b0;
    b1.speed = 2'd0; b1.pause = 1'b0;
    b2.speed = 2'd0; b2.pause = 1'b0;

    // 1: default cadence at 1x.
    hold_reset(0);
    for (int i = 0; i < 3600; i++) begin
      tick();
      check("t1_f1",  b0.ce_f1,  32'(cyc % 24 == 1));
      check("t1_f2",  b0.ce_f2,  32'(cyc % 24 == 3));
      check("t1_pix", b0.ce_pix, 32'(cyc % 3 == 1));
      check("t1_aux", b0.ce_aux, 32'(cyc % 3571 == 1));
      check("t1_spd", b0.speed_cur, 32'd0);
    end

    // 2: speed=1 requested mid-period takes effect at the next period.
    b0.speed = 2'd0;
    hold_reset(0);
    for (int i = 0; i < 60; i++) begin
      tick();
      check("t2_f1", b0.ce_f1, 32'(cyc == 1 || (cyc >= 25 && (cyc - 25) % 12 == 0)));
      check("t2_f2", b0.ce_f2, 32'(cyc == 3 || (cyc >= 27 && (cyc - 27) % 12 == 0)));
      if (cyc != 24) check("t2_spd", b0.speed_cur, (cyc >= 25) ? 32'd1 : 32'd0);
      if (cyc == 9) b0.speed = 2'd1;
    end

    // 3: speed=3 on the default build -> 3-clk sub-period.
    b0.speed = 2'd3;
    hold_reset(0);
    for (int i = 0; i < 96; i++) begin
      tick();
      check("t3_f1", b0.ce_f1, 32'(cyc == 1 || (cyc >= 25 && (cyc - 25) % 3 == 0)));
      check("t3_f2", b0.ce_f2, 32'(cyc == 3 || (cyc >= 27 && (cyc - 27) % 3 == 0)));
      if (cyc != 24) check("t3_spd", b0.speed_cur, (cyc >= 25) ? 32'd3 : 32'd0);
    end

    // 3b: MAX_SPEED=2 build clamps speed=3 to 2 -> 6-clk sub-period.
    b1.speed = 2'd3;
    hold_reset(1);
    for (int i = 0; i < 72; i++) begin
      tick();
      check("t3b_f1", b1.ce_f1, 32'(cyc == 1 || (cyc >= 25 && (cyc - 25) % 6 == 0)));
      check("t3b_f2", b1.ce_f2, 32'(cyc == 3 || (cyc >= 27 && (cyc - 27) % 6 == 0)));
      if (cyc != 24) check("t3b_spd", b1.speed_cur, (cyc >= 25) ? 32'd2 : 32'd0);
    end

    // 4: pause between f1 and f2 keeps the pair; release resumes at next f1 slot.
    b0.speed = 2'd0;
    b0.pause = 1'b0;
    hold_reset(0);
    for (int i = 0; i < 100; i++) begin
      tick();
      check("t4_f1",  b0.ce_f1,  32'(cyc == 1 || cyc == 73 || cyc == 97));
      check("t4_f2",  b0.ce_f2,  32'(cyc == 3 || cyc == 75 || cyc == 99));
      check("t4_pix", b0.ce_pix, 32'(cyc % 3 == 1));
      check("t4_aux", b0.ce_aux, 32'(cyc == 1));
      if (cyc == 1)  b0.pause = 1'b1;
      if (cyc == 59) b0.pause = 1'b0;
    end

    // 5: one-cycle reset with an f2 pending and speed_cur=1.
    b0.speed = 2'd1;
    b0.pause = 1'b0;
    hold_reset(0);
    for (int i = 0; i < 25; i++) begin
      tick();
      check("t5a_f1", b0.ce_f1, 32'(cyc == 1 || cyc == 25));
    end
    check("t5a_spd", b0.speed_cur, 32'd1);
    r0 = 1'b1;
    tick();
    check("t5_rst_outs", 32'(outs(0)), 32'd0);
    r0 = 1'b0;
    cyc = 0;
    for (int i = 0; i < 36; i++) begin
      tick();
      check("t5_f1",  b0.ce_f1,  32'(cyc == 1 || cyc == 25));
      check("t5_f2",  b0.ce_f2,  32'(cyc == 3 || cyc == 27));
      check("t5_pix", b0.ce_pix, 32'(cyc % 3 == 1));
      check("t5_aux", b0.ce_aux, 32'(cyc == 1));
      if (cyc != 24) check("t5_spd", b0.speed_cur, (cyc >= 25) ? 32'd1 : 32'd0);
    end

    // 6: small-divider build, directed cadence at 1x.
    b2.speed = 2'd0;
    b2.pause = 1'b0;
    hold_reset(2);
    for (int i = 0; i < 32; i++) begin
      tick();
      check("t6_f1",  b2.ce_f1,  32'(cyc % 16 == 1));
      check("t6_f2",  b2.ce_f2,  32'(cyc % 16 == 2));
      check("t6_pix", b2.ce_pix, 32'd1);
      check("t6_aux", b2.ce_aux, 32'(cyc % 5 == 1));
    end

    // 6: f1 period 8/4/2 for speeds 1..3, f2 one clk after f1.
    for (int s = 1; s < 4; s++) begin
      b2.speed = 2'(s);
      n = 0;
      while (b2.speed_cur != 2'(s) && n < 40) begin
        tick();
        n++;
      end
      check("t6_spd_reach", b2.speed_cur, 32'(s));
      n = 0;
      while (!b2.ce_f1 && n < 40) begin
        tick();
        n++;
      end
      check("t6_f1_found", b2.ce_f1, 32'd1);
      tick();
      g = 1;
      check("t6_f2_follow", b2.ce_f2, 32'd1);
      while (!b2.ce_f1 && g < 40) begin
        tick();
        g++;
      end
      check("t6_period", 32'(g), 32'(16 >> s));
    end

    // 6: random speed/pause soak; f2 must follow f1 exactly and never overlap.
    prev_f1 = b2.ce_f1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0)  b2.speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) b2.pause = ~b2.pause;
      tick();
      check("t6r_overlap", 32'(b2.ce_f1 & b2.ce_f2), 32'd0);
      check("t6r_pair",    b2.ce_f2, 32'(prev_f1));
      check("t6r_pix",     b2.ce_pix, 32'd1);
      check("t6r_aux",     b2.ce_aux, 32'(cyc % 5 == 1));
      prev_f1 = b2.ce_f1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
